// File: rtl/video_pkg.sv
// Shared types for the video layer mixer: blend modes and per-layer configuration.
package video_pkg;

    // Key fields are stored at a fixed width so the struct can stay unparameterised;
    // the mixer zero-extends pixels to this width when comparing against a key.
    localparam int KEY_W_MAX = 16;

    typedef enum logic [1:0] {
        BLEND_REPLACE = 2'd0,
        BLEND_AVERAGE = 2'd1,
        BLEND_ADD_SAT = 2'd2,
        BLEND_RSVD    = 2'd3
    } blend_mode_t;

    typedef struct packed {
        logic                       en;
        blend_mode_t                mode;
        logic [2:0][KEY_W_MAX-1:0]  key;   // [2]=red, [1]=green, [0]=blue
    } layer_cfg_t;

    localparam layer_cfg_t LAYER_CFG_RESET = '{en: 1'b1, mode: BLEND_REPLACE, key: '0};

endpackage

// File: rtl/video_blend_op.sv
// One step of the layer fold: combines a layer pixel into the accumulator per channel.
module video_blend_op
    import video_pkg::*;
#(
    parameter int COLSPC = 10
) (
    input  logic [2:0][COLSPC-1:0] pix,
    input  logic [2:0][COLSPC-1:0] acc,
    input  blend_mode_t            mode,
    output logic [2:0][COLSPC-1:0] acc_next
);

    logic [2:0][COLSPC:0] sum;

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            sum[c] = {1'b0, pix[c]} + {1'b0, acc[c]};
        end
    end

    always_comb begin
        acc_next = pix;
        for (int c = 0; c < 3; c++) begin
            case (mode)
                BLEND_AVERAGE: acc_next[c] = sum[c][COLSPC:1];
                BLEND_ADD_SAT: acc_next[c] = sum[c][COLSPC] ? {COLSPC{1'b1}} : sum[c][COLSPC-1:0];
                default:       acc_next[c] = pix[c];
            endcase
        end
    end

endmodule

// File: rtl/video_layer_mixer.sv
// Priority/blend mixer for NLAYERS pixel layers with frame-synchronous double-buffered
// configuration. Fixed two-cycle latency: input register stage, then fold plus output register.
module video_layer_mixer
    import video_pkg::*;
#(
    parameter int NLAYERS = 4,
    parameter int COLSPC  = 10
) (
    input  logic                             video_clk_pix,
    input  logic                             video_rst_n,
    input  logic                             video_enable,
    input  logic                             hsync,
    input  logic                             vsync,
    input  logic                             frame_start,
    input  logic                             line_start,
    input  logic [NLAYERS-1:0][COLSPC-1:0]   layer_red,
    input  logic [NLAYERS-1:0][COLSPC-1:0]   layer_green,
    input  logic [NLAYERS-1:0][COLSPC-1:0]   layer_blue,
    input  logic                             cfg_wr,
    input  logic [$clog2(NLAYERS)-1:0]       cfg_layer,
    input  logic                             cfg_en,
    input  logic [1:0]                       cfg_mode,
    input  logic [3*COLSPC-1:0]              cfg_key,
    output logic                             cfg_pending,
    output logic [COLSPC-1:0]                red,
    output logic [COLSPC-1:0]                green,
    output logic [COLSPC-1:0]                blue,
    output logic                             out_video_enable,
    output logic                             out_hsync,
    output logic                             out_vsync,
    output logic                             out_frame_start,
    output logic                             out_line_start
);

    layer_cfg_t pend_cfg [NLAYERS];
    layer_cfg_t act_cfg  [NLAYERS];
    layer_cfg_t wr_cfg;
    logic       wr_ok;
    logic       do_copy;

    assign wr_ok   = cfg_wr && (32'(cfg_layer) < NLAYERS);
    assign do_copy = frame_start && cfg_pending;

    always_comb begin
        wr_cfg        = LAYER_CFG_RESET;
        wr_cfg.en     = cfg_en;
        wr_cfg.mode   = blend_mode_t'(cfg_mode);
        wr_cfg.key[2] = KEY_W_MAX'(cfg_key[3*COLSPC-1:2*COLSPC]);
        wr_cfg.key[1] = KEY_W_MAX'(cfg_key[2*COLSPC-1:COLSPC]);
        wr_cfg.key[0] = KEY_W_MAX'(cfg_key[COLSPC-1:0]);
    end

    // The copy reads pending before this cycle's write lands, so a write that
    // coincides with frame_start waits for the next one and keeps the flag set.
    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            for (int i = 0; i < NLAYERS; i++) begin
                pend_cfg[i] <= LAYER_CFG_RESET;
                act_cfg[i]  <= LAYER_CFG_RESET;
            end
            cfg_pending <= 1'b0;
        end else begin
            if (do_copy) begin
                for (int i = 0; i < NLAYERS; i++) begin
                    act_cfg[i] <= pend_cfg[i];
                end
            end
            if (wr_ok) begin
                pend_cfg[cfg_layer] <= wr_cfg;
            end
            if (wr_ok) begin
                cfg_pending <= 1'b1;
            end else if (do_copy) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    logic                                   s1_en, s1_hs, s1_vs, s1_fs, s1_ls;
    logic [NLAYERS-1:0][2:0][COLSPC-1:0]    s1_pix;

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            s1_en  <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_fs  <= 1'b0;
            s1_ls  <= 1'b0;
            s1_pix <= '0;
        end else begin
            s1_en <= video_enable;
            s1_hs <= hsync;
            s1_vs <= vsync;
            s1_fs <= frame_start;
            s1_ls <= line_start;
            for (int i = 0; i < NLAYERS; i++) begin
                s1_pix[i] <= {layer_red[i], layer_green[i], layer_blue[i]};
            end
        end
    end

    logic [NLAYERS-1:0]                   vis;
    logic [NLAYERS:0][2:0][COLSPC-1:0]    acc;
    logic [NLAYERS-1:0][2:0][COLSPC-1:0]  blend;

    always_comb begin
        vis = '0;
        for (int i = 0; i < NLAYERS; i++) begin
            vis[i] = act_cfg[i].en &&
                     (act_cfg[i].key != {KEY_W_MAX'(s1_pix[i][2]),
                                         KEY_W_MAX'(s1_pix[i][1]),
                                         KEY_W_MAX'(s1_pix[i][0])});
        end
    end

    // Fold runs from the lowest-priority layer (NLAYERS-1) up to layer 0.
    assign acc[NLAYERS] = '0;

    for (genvar i = 0; i < NLAYERS; i++) begin : g_fold
        video_blend_op #(.COLSPC(COLSPC)) u_blend (
            .pix      (s1_pix[i]),
            .acc      (acc[i+1]),
            .mode     (act_cfg[i].mode),
            .acc_next (blend[i])
        );
        assign acc[i] = vis[i] ? blend[i] : acc[i+1];
    end

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            red              <= '0;
            green            <= '0;
            blue             <= '0;
            out_video_enable <= 1'b0;
            out_hsync        <= 1'b0;
            out_vsync        <= 1'b0;
            out_frame_start  <= 1'b0;
            out_line_start   <= 1'b0;
        end else begin
            red              <= s1_en ? acc[0][2] : '0;
            green            <= s1_en ? acc[0][1] : '0;
            blue             <= s1_en ? acc[0][0] : '0;
            out_video_enable <= s1_en;
            out_hsync        <= s1_hs;
            out_vsync        <= s1_vs;
            out_frame_start  <= s1_fs;
            out_line_start   <= s1_ls;
        end
    end

endmodule

// File: tb/tb_video_layer_mixer.sv
// Self-checking bench for video_layer_mixer: behavioural model plus directed literal checks.
module tb_video_layer_mixer;

    localparam int NL   = 4;
    localparam int CS   = 10;
    localparam int MAXV = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic video_enable = 0, hsync = 0, vsync = 0, frame_start = 0, line_start = 0;
    logic [NL-1:0][CS-1:0] layer_red = '0, layer_green = '0, layer_blue = '0;
    logic cfg_wr = 0;
    logic [1:0] cfg_layer = '0;
    logic cfg_en = 0;
    logic [1:0] cfg_mode = '0;
    logic [3*CS-1:0] cfg_key = '0;
    logic cfg_pending;
    logic [CS-1:0] red, green, blue;
    logic out_video_enable, out_hsync, out_vsync, out_frame_start, out_line_start;

    video_layer_mixer #(.NLAYERS(NL), .COLSPC(CS)) dut (
        .video_clk_pix    (clk),
        .video_rst_n      (rst_n),
        .video_enable     (video_enable),
        .hsync            (hsync),
        .vsync            (vsync),
        .frame_start      (frame_start),
        .line_start       (line_start),
        .layer_red        (layer_red),
        .layer_green      (layer_green),
        .layer_blue       (layer_blue),
        .cfg_wr           (cfg_wr),
        .cfg_layer        (cfg_layer),
        .cfg_en           (cfg_en),
        .cfg_mode         (cfg_mode),
        .cfg_key          (cfg_key),
        .cfg_pending      (cfg_pending),
        .red              (red),
        .green            (green),
        .blue             (blue),
        .out_video_enable (out_video_enable),
        .out_hsync        (out_hsync),
        .out_vsync        (out_vsync),
        .out_frame_start  (out_frame_start),
        .out_line_start   (out_line_start)
    );

    int checks = 0;
    int errors = 0;

    // Model configuration: index [layer], key channel 0=r 1=g 2=b.
    int act_en [NL], act_mode [NL], act_key [NL][3];
    int pnd_en [NL], pnd_mode [NL], pnd_key [NL][3];
    bit m_flag;
    logic [34:0] exp_out, exp_next;
    bit exp_pend;
    bit chk_on = 0;

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            act_en[i] = 1; act_mode[i] = 0;
            pnd_en[i] = 1; pnd_mode[i] = 0;
            for (int c = 0; c < 3; c++) begin
                act_key[i][c] = 0;
                pnd_key[i][c] = 0;
            end
        end
        m_flag   = 0;
        exp_out  = '0;
        exp_next = '0;
        exp_pend = 0;
    endtask

    function automatic logic [34:0] model_pixel();
        int acc [3];
        int p [3];
        bit v;
        for (int c = 0; c < 3; c++) acc[c] = 0;
        for (int i = NL - 1; i >= 0; i--) begin
            p[0] = int'(layer_red[i]);
            p[1] = int'(layer_green[i]);
            p[2] = int'(layer_blue[i]);
            v = (act_en[i] != 0) &&
                (p[0] != act_key[i][0] || p[1] != act_key[i][1] || p[2] != act_key[i][2]);
            if (v) begin
                for (int c = 0; c < 3; c++) begin
                    if (act_mode[i] == 1)      acc[c] = (p[c] + acc[c]) / 2;
                    else if (act_mode[i] == 2) acc[c] = (p[c] + acc[c] > MAXV) ? MAXV : p[c] + acc[c];
                    else                       acc[c] = p[c];
                end
            end
        end
        if (!video_enable) for (int c = 0; c < 3; c++) acc[c] = 0;
        return {10'(acc[0]), 10'(acc[1]), 10'(acc[2]),
                video_enable, hsync, vsync, frame_start, line_start};
    endfunction

    // Advance one pixel clock: update the model for the inputs now applied,
    // then let the edge happen and move the expected pipeline along.
    task automatic step();
        logic [34:0] nx;
        bit copy;
        nx = '0;
        if (rst_n) begin
            copy = frame_start && m_flag;
            if (copy) begin
                act_en   = pnd_en;
                act_mode = pnd_mode;
                act_key  = pnd_key;
            end
            nx = model_pixel();
            if (cfg_wr && int'(cfg_layer) < NL) begin
                pnd_en[cfg_layer]    = cfg_en ? 1 : 0;
                pnd_mode[cfg_layer]  = int'(cfg_mode);
                pnd_key[cfg_layer][0] = int'(cfg_key[29:20]);
                pnd_key[cfg_layer][1] = int'(cfg_key[19:10]);
                pnd_key[cfg_layer][2] = int'(cfg_key[9:0]);
                m_flag = 1;
            end else if (copy) begin
                m_flag = 0;
            end
        end
        @(posedge clk);
        exp_out  = exp_next;
        exp_next = nx;
        exp_pend = rst_n ? m_flag : 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if ({red, green, blue, out_video_enable, out_hsync, out_vsync,
                 out_frame_start, out_line_start} !== exp_out) begin
                errors++;
                $display("FAIL model_pixel t=%0t got %h want %h", $time,
                         {red, green, blue, out_video_enable, out_hsync, out_vsync,
                          out_frame_start, out_line_start}, exp_out);
            end
            checks++;
            if (cfg_pending !== exp_pend) begin
                errors++;
                $display("FAIL model_pending t=%0t got %b want %b", $time, cfg_pending, exp_pend);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic set_layer(input int i, input int r, input int g, input int b);
        layer_red[i]   = 10'(r);
        layer_green[i] = 10'(g);
        layer_blue[i]  = 10'(b);
    endtask

    task automatic wr_step(input int l, input bit en, input int mode,
                           input int kr, input int kg, input int kb, input bit fs);
        cfg_layer   = 2'(l);
        cfg_en      = en;
        cfg_mode    = 2'(mode);
        cfg_key     = {10'(kr), 10'(kg), 10'(kb)};
        cfg_wr      = 1'b1;
        frame_start = fs;
        step();
        cfg_wr      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fs_step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        model_reset();
        chk_on = 1;
        repeat (3) step();
        check_lit("reset_rgb", {2'b0, red, green, blue}, 32'h0);
        check_lit("reset_pending", {31'b0, cfg_pending}, 32'h0);

        // Reset defaults: plain priority with black transparent, 2-cycle latency.
        rst_n = 1'b1;
        video_enable = 1'b1;
        set_layer(1, 'h3FF, 0, 0);
        step();
        check_lit("latency_not_early", {22'b0, red}, 32'h0);
        step();
        check_lit("default_prio", {2'b0, red, green, blue}, {2'b0, 10'h3FF, 10'h0, 10'h0});

        // AVERAGE
        wr_step(0, 1, 1, 0, 0, 0, 0);
        check_lit("avg_pending", {31'b0, cfg_pending}, 32'h1);
        fs_step();
        set_layer(0, 'h100, 0, 0);
        set_layer(1, 'h300, 0, 0);
        step(); step();
        check_lit("avg_100_300", {22'b0, red}, 32'h200);
        set_layer(0, 'h001, 0, 0);
        set_layer(1, 0, 0, 0);
        step(); step();
        check_lit("avg_001_000", {22'b0, red}, 32'h0);

        // ADD_SAT
        wr_step(0, 1, 2, 0, 0, 0, 0);
        fs_step();
        set_layer(0, 'h300, 0, 0);
        set_layer(1, 'h200, 0, 0);
        step(); step();
        check_lit("addsat_sat", {22'b0, red}, 32'h3FF);

        // Transparent key: white layer0 reveals layer1 from the next frame_start.
        wr_step(0, 1, 0, 'h3FF, 'h3FF, 'h3FF, 0);
        set_layer(0, 'h3FF, 'h3FF, 'h3FF);
        set_layer(1, 'h123, 'h045, 'h067);
        step(); step();
        check_lit("key_before_fs", {2'b0, red, green, blue}, {2'b0, 10'h3FF, 10'h3FF, 10'h3FF});
        check_lit("key_pending_held", {31'b0, cfg_pending}, 32'h1);
        fs_step();
        check_lit("key_pending_clr", {31'b0, cfg_pending}, 32'h0);
        step();
        check_lit("key_out_fs", {31'b0, out_frame_start}, 32'h1);
        check_lit("key_reveal", {2'b0, red, green, blue}, {2'b0, 10'h123, 10'h045, 10'h067});

        // Write coinciding with frame_start waits for the following frame_start.
        wr_step(2, 1, 0, 0, 0, 0, 0);
        wr_step(0, 1, 0, 0, 0, 0, 1);
        check_lit("coin_pending", {31'b0, cfg_pending}, 32'h1);
        step();
        check_lit("coin_fs_old", {2'b0, red, green, blue}, {2'b0, 10'h123, 10'h045, 10'h067});
        repeat (3) step();
        check_lit("coin_pending_hold", {31'b0, cfg_pending}, 32'h1);
        fs_step();
        step();
        check_lit("coin_applied", {2'b0, red, green, blue}, {2'b0, 10'h3FF, 10'h3FF, 10'h3FF});
        check_lit("coin_pending_clr", {31'b0, cfg_pending}, 32'h0);

        // Reset mid-frame with a pending disable of layer0.
        wr_step(0, 0, 0, 0, 0, 0, 0);
        check_lit("rst_mid_pending", {31'b0, cfg_pending}, 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_lit("rst_mid_rgb", {2'b0, red, green, blue}, 32'h0);
        check_lit("rst_mid_ven", {31'b0, out_video_enable}, 32'h0);
        check_lit("rst_mid_pend0", {31'b0, cfg_pending}, 32'h0);
        step(); step();
        rst_n = 1'b1;
        fs_step();
        step();
        check_lit("rst_write_lost", {2'b0, red, green, blue}, {2'b0, 10'h3FF, 10'h3FF, 10'h3FF});

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NL; i++) begin
                int ch [3];
                for (int c = 0; c < 3; c++) begin
                    case ($urandom_range(0, 3))
                        0:       ch[c] = 0;
                        1:       ch[c] = MAXV;
                        default: ch[c] = int'($urandom_range(0, MAXV));
                    endcase
                end
                set_layer(i, ch[0], ch[1], ch[2]);
            end
            video_enable = ($urandom_range(0, 7) != 0);
            hsync        = 1'($urandom_range(0, 1));
            vsync        = 1'($urandom_range(0, 1));
            line_start   = 1'($urandom_range(0, 1));
            frame_start  = ($urandom_range(0, 15) == 0);
            cfg_wr       = ($urandom_range(0, 5) == 0);
            cfg_layer    = 2'($urandom_range(0, NL - 1));
            cfg_en       = ($urandom_range(0, 4) != 0);
            cfg_mode     = 2'($urandom_range(0, 3));
            cfg_key      = {($urandom_range(0, 1) != 0) ? 10'h3FF : 10'h0,
                            ($urandom_range(0, 1) != 0) ? 10'h3FF : 10'h0,
                            ($urandom_range(0, 1) != 0) ? 10'h3FF : 10'h0};
            if (n == 200) begin
                rst_n = 1'b0;
                model_reset();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        cfg_wr = 1'b0;
        frame_start = 1'b0;
        step(); step();
        @(negedge clk);
        #1;
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
